io_switch_ctrl: RTL and testbench

IO_SWITCH_CTRL -- requirements
Module: io_switch_ctrl

---
 rtl/io_switch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_io_switch_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_switch_ctrl.sv
// Purpose : hands a shared set of north/east/west pads to one of N_MACROS user macros, with a break-before-make guard on every switch.
// Latency : pad outputs follow the owning macro combinationally (one registered cycle with IO_SWITCH_OUT_REG_EN); select changes take effect after the guard.
// Backpr. : none; cfg_valid_i is a fire-and-forget strobe, and the last request seen during a guard wins.
//
// Optional feature macro: IO_SWITCH_OUT_REG_EN (registers every io_* output).
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   cfg_valid_i, cfg_sel_i              switch request; cfg_sel_i >= N_MACROS parks the pads
//   north_*_i / east_*_i / west_*_i     per-macro pad drive, macro k in slice k
//   io_north_* / io_east_* / io_west_*  pad drive of the current owner, 0 when no owner
//   active_o, sel_o, busy_o             owner present, owner index, guard in progress
module io_switch_ctrl #(
    parameter int N_MACROS     = 4,
    parameter int N_NORTH      = 10,
    parameter int N_EW         = 14,
    parameter int GUARD_CYCLES = 4,
    localparam int SEL_W       = $clog2(N_MACROS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cfg_valid_i,
    input  logic [SEL_W:0]            cfg_sel_i,
    input  logic [N_MACROS*N_NORTH-1:0] north_o_i,
    input  logic [N_MACROS*N_NORTH-1:0] north_oe_i,
    input  logic [N_MACROS*N_EW-1:0]  east_o_i,
    input  logic [N_MACROS*N_EW-1:0]  east_oe_i,
    input  logic [N_MACROS*N_EW-1:0]  west_o_i,
    input  logic [N_MACROS*N_EW-1:0]  west_oe_i,
    output logic [N_NORTH-1:0]        io_north_o,
    output logic [N_NORTH-1:0]        io_north_oe,
    output logic [N_EW-1:0]           io_east_o,
    output logic [N_EW-1:0]           io_east_oe,
    output logic [N_EW-1:0]           io_west_o,
    output logic [N_EW-1:0]           io_west_oe,
    output logic                      active_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic                      busy_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GUARD  = 2'd2;

    localparam logic [7:0]     GUARD_LOAD = 8'(GUARD_CYCLES);
    localparam logic [SEL_W:0] NUM_SEL    = (SEL_W+1)'(N_MACROS);
    // All-ones is always >= N_MACROS because N_MACROS <= 2**SEL_W.
    localparam logic [SEL_W:0] PARK_SEL   = '1;

    logic [1:0]     state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [SEL_W:0] owner_q, owner_d;
    logic [SEL_W:0] pend_q, pend_d;
    logic [SEL_W:0] pend_eff;

    // A request arriving on the final guard cycle still counts: last request wins.
    assign pend_eff = cfg_valid_i ? cfg_sel_i : pend_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i && (cfg_sel_i < NUM_SEL)) begin
                    owner_d = cfg_sel_i;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Re-selecting the current owner is a no-op; anything else,
                // park included, goes through the guard.
                if (cfg_valid_i && (cfg_sel_i != owner_q)) begin
                    pend_d  = cfg_sel_i;
                    cnt_d   = GUARD_LOAD;
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                pend_d = pend_eff;
                if (cnt_q == 8'd1) begin
                    cnt_d  = 8'd0;
                    pend_d = PARK_SEL;
                    if (pend_eff < NUM_SEL) begin
                        owner_d = pend_eff;
                        state_d = ST_ACTIVE;
                    end else begin
                        owner_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                owner_d = '0;
                pend_d  = PARK_SEL;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            owner_q <= '0;
            pend_q  <= PARK_SEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            pend_q  <= pend_d;
        end
    end

    assign active_o = (state_q == ST_ACTIVE);
    assign busy_o   = (state_q == ST_GUARD);
    assign sel_o    = active_o ? owner_q[SEL_W-1:0] : '0;

    // Owner slice select; everything stays 0 outside ACTIVE.
    logic [N_NORTH-1:0] north_o_mux, north_oe_mux;
    logic [N_EW-1:0]    east_o_mux, east_oe_mux, west_o_mux, west_oe_mux;

    always_comb begin
        north_o_mux  = '0;
        north_oe_mux = '0;
        east_o_mux   = '0;
        east_oe_mux  = '0;
        west_o_mux   = '0;
        west_oe_mux  = '0;
        for (int k = 0; k < N_MACROS; k++) begin
            if (active_o && (owner_q == (SEL_W+1)'(k))) begin
                north_o_mux  = north_o_i[k*N_NORTH +: N_NORTH];
                north_oe_mux = north_oe_i[k*N_NORTH +: N_NORTH];
                east_o_mux   = east_o_i[k*N_EW +: N_EW];
                east_oe_mux  = east_oe_i[k*N_EW +: N_EW];
                west_o_mux   = west_o_i[k*N_EW +: N_EW];
                west_oe_mux  = west_oe_i[k*N_EW +: N_EW];
            end
        end
    end

`ifdef IO_SWITCH_OUT_REG_EN
    // Load only while staying ACTIVE, so the registered pads are already 0
    // on the first GUARD/IDLE cycle and on the first ACTIVE cycle.
    logic hold_active;
    assign hold_active = active_o && (state_d == ST_ACTIVE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            io_north_o  <= '0;
            io_north_oe <= '0;
            io_east_o   <= '0;
            io_east_oe  <= '0;
            io_west_o   <= '0;
            io_west_oe  <= '0;
        end else if (hold_active) begin
            io_north_o  <= north_o_mux;
            io_north_oe <= north_oe_mux;
            io_east_o   <= east_o_mux;
            io_east_oe  <= east_oe_mux;
            io_west_o   <= west_o_mux;
            io_west_oe  <= west_oe_mux;
        end else begin
            io_north_o  <= '0;
            io_north_oe <= '0;
            io_east_o   <= '0;
            io_east_oe  <= '0;
            io_west_o   <= '0;
            io_west_oe  <= '0;
        end
    end
`else
    assign io_north_o  = north_o_mux;
    assign io_north_oe = north_oe_mux;
    assign io_east_o   = east_o_mux;
    assign io_east_oe  = east_oe_mux;
    assign io_west_o   = west_o_mux;
    assign io_west_oe  = west_oe_mux;
`endif

endmodule

// File: tb/tb_io_switch_ctrl.sv
// Purpose : self-checking bench for io_switch_ctrl against an ownership/guard-countdown model.
// Latency : model tracks comb pads, or one-cycle registered pads with IO_SWITCH_OUT_REG_EN.
// Backpr. : none; stimulus is a mix of directed scenarios and random requests/resets.
module tb_io_switch_ctrl;

    localparam int NM = 4;
    localparam int NN = 10;
    localparam int NE = 14;
    localparam int GC = 4;
    localparam int SW = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              cfg_valid_i;
    logic [SW:0]       cfg_sel_i;
    logic [NM*NN-1:0]  north_o_i, north_oe_i;
    logic [NM*NE-1:0]  east_o_i, east_oe_i, west_o_i, west_oe_i;
    logic [NN-1:0]     io_north_o, io_north_oe;
    logic [NE-1:0]     io_east_o, io_east_oe, io_west_o, io_west_oe;
    logic              active_o;
    logic [SW-1:0]     sel_o;
    logic              busy_o;

    int checks   = 0;
    int failures = 0;

    io_switch_ctrl #(.N_MACROS(NM), .N_NORTH(NN), .N_EW(NE), .GUARD_CYCLES(GC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cfg_valid_i(cfg_valid_i), .cfg_sel_i(cfg_sel_i),
        .north_o_i(north_o_i), .north_oe_i(north_oe_i),
        .east_o_i(east_o_i), .east_oe_i(east_oe_i),
        .west_o_i(west_o_i), .west_oe_i(west_oe_i),
        .io_north_o(io_north_o), .io_north_oe(io_north_oe),
        .io_east_o(io_east_o), .io_east_oe(io_east_oe),
        .io_west_o(io_west_o), .io_west_oe(io_west_oe),
        .active_o(active_o), .sel_o(sel_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NM*NN; i++) begin
            north_o_i[i]  = 1'($urandom);
            north_oe_i[i] = 1'($urandom);
        end
        for (int i = 0; i < NM*NE; i++) begin
            east_o_i[i]  = 1'($urandom);
            east_oe_i[i] = 1'($urandom);
            west_o_i[i]  = 1'($urandom);
            west_oe_i[i] = 1'($urandom);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 means no owner; guard_left > 0 means the pads are in the guard window.
    int m_owner = -1;
    int m_guard = 0;
    int m_pend  = 7;
    logic [NN-1:0] m_reg_no, m_reg_noe;
    logic [NE-1:0] m_reg_eo, m_reg_eoe, m_reg_wo, m_reg_woe;
    bit   m_was_act;

    function automatic bit m_active();
        return (m_guard == 0) && (m_owner >= 0);
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_owner = -1; m_guard = 0; m_pend = 7;
            m_reg_no = '0; m_reg_noe = '0; m_reg_eo = '0;
            m_reg_eoe = '0; m_reg_wo = '0; m_reg_woe = '0;
        end else begin
            m_was_act = m_active();
            if (m_guard > 0) begin
                if (cfg_valid_i) m_pend = int'(cfg_sel_i);
                if (m_guard == 1) begin
                    m_owner = (m_pend < NM) ? m_pend : -1;
                    m_guard = 0;
                end else begin
                    m_guard = m_guard - 1;
                end
            end else if (m_owner >= 0) begin
                if (cfg_valid_i && int'(cfg_sel_i) != m_owner) begin
                    m_pend  = int'(cfg_sel_i);
                    m_guard = GC;
                end
            end else if (cfg_valid_i && int'(cfg_sel_i) < NM) begin
                m_owner = int'(cfg_sel_i);
            end
            if (m_was_act && m_active()) begin
                m_reg_no  = north_o_i[m_owner*NN +: NN];
                m_reg_noe = north_oe_i[m_owner*NN +: NN];
                m_reg_eo  = east_o_i[m_owner*NE +: NE];
                m_reg_eoe = east_oe_i[m_owner*NE +: NE];
                m_reg_wo  = west_o_i[m_owner*NE +: NE];
                m_reg_woe = west_oe_i[m_owner*NE +: NE];
            end else begin
                m_reg_no = '0; m_reg_noe = '0; m_reg_eo = '0;
                m_reg_eoe = '0; m_reg_wo = '0; m_reg_woe = '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NN-1:0] e_no, e_noe;
    logic [NE-1:0] e_eo, e_eoe, e_wo, e_woe;

    always @(negedge clk_i) begin
`ifdef IO_SWITCH_OUT_REG_EN
        e_no = m_reg_no; e_noe = m_reg_noe; e_eo = m_reg_eo;
        e_eoe = m_reg_eoe; e_wo = m_reg_wo; e_woe = m_reg_woe;
`else
        if (m_active()) begin
            e_no  = north_o_i[m_owner*NN +: NN];
            e_noe = north_oe_i[m_owner*NN +: NN];
            e_eo  = east_o_i[m_owner*NE +: NE];
            e_eoe = east_oe_i[m_owner*NE +: NE];
            e_wo  = west_o_i[m_owner*NE +: NE];
            e_woe = west_oe_i[m_owner*NE +: NE];
        end else begin
            e_no = '0; e_noe = '0; e_eo = '0; e_eoe = '0; e_wo = '0; e_woe = '0;
        end
`endif
        chk("cyc_active", 64'(active_o), 64'(m_active()));
        chk("cyc_busy",   64'(busy_o),   64'(m_guard > 0));
        chk("cyc_sel",    64'(sel_o),    64'(m_active() ? m_owner : 0));
        chk("cyc_north",  64'({io_north_oe, io_north_o}), 64'({e_noe, e_no}));
        chk("cyc_east",   64'({io_east_oe, io_east_o}),   64'({e_eoe, e_eo}));
        chk("cyc_west",   64'({io_west_oe, io_west_o}),   64'({e_woe, e_wo}));
    end

    // Input data churns every cycle, 2 time units after the active edge.
    always @(posedge clk_i) begin
        #2;
        randomize_data();
    end

    task automatic req(input int sel);
        @(posedge clk_i);
        #2;
        cfg_valid_i = 1'b1;
        cfg_sel_i   = (SW+1)'(sel);
        @(posedge clk_i);
        #2;
        cfg_valid_i = 1'b0;
    endtask

    task automatic chk_guard_cycle(input string name);
        chk({name, "_busy"}, 64'(busy_o), 64'd1);
        chk({name, "_oe"}, 64'({io_north_oe, io_east_oe, io_west_oe}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [NN-1:0] save_n;

    initial begin
        rst_ni      = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_sel_i   = '0;
        randomize_data();
        #1;
        chk("rst_active", 64'(active_o), 64'd0);
        chk("rst_sel",    64'(sel_o),    64'd0);
        chk("rst_busy",   64'(busy_o),   64'd0);
        chk("rst_pads",   64'({io_north_oe, io_east_oe, io_west_oe}), 64'd0);
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // Idle -> owner 2
        req(2);
        #1;
        chk("s2_active", 64'(active_o), 64'd1);
        chk("s2_sel",    64'(sel_o),    64'd2);
        save_n = north_o_i[29:20];
`ifdef IO_SWITCH_OUT_REG_EN
        chk("s2_north_first", 64'(io_north_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("s2_north_reg", 64'(io_north_o), 64'(save_n));
`else
        chk("s2_north", 64'(io_north_o), 64'(save_n));
`endif

        // 2 -> 1 through a 4-cycle guard
        req(1);
        #1;
        chk_guard_cycle("g1");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            chk_guard_cycle("g1");
        end
        @(posedge clk_i);
        #1;
        chk("g1_exit_busy", 64'(busy_o), 64'd0);
        chk("g1_exit_sel",  64'(sel_o),  64'd1);
`ifndef IO_SWITCH_OUT_REG_EN
        chk("g1_exit_north", 64'(io_north_o), 64'(north_o_i[19:10]));
        chk("g1_exit_east_oe", 64'(io_east_oe), 64'(east_oe_i[27:14]));
`endif

        // Requests 3 then 0 inside one guard: 0 wins, guard length unchanged
        req(3);
        #1;
        chk_guard_cycle("g2");
        req(0);
        @(posedge clk_i);
        #1;
        chk_guard_cycle("g2");
        @(posedge clk_i);
        #1;
        chk("g2_exit_active", 64'(active_o), 64'd1);
        chk("g2_exit_sel",    64'(sel_o),    64'd0);

        // Park request: guard, then idle
        req(7);
        #1;
        chk_guard_cycle("g3");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            chk_guard_cycle("g3");
        end
        @(posedge clk_i);
        #1;
        chk("park_active", 64'(active_o), 64'd0);
        chk("park_sel",    64'(sel_o),    64'd0);
        chk("park_busy",   64'(busy_o),   64'd0);
        chk("park_pads",   64'({io_north_o, io_north_oe, io_east_oe, io_west_oe}), 64'd0);

        // Reset in the second guard cycle discards the pending select
        req(2);
        req(1);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("rstg_active", 64'(active_o), 64'd0);
        chk("rstg_busy",   64'(busy_o),   64'd0);
        chk("rstg_pads",   64'({io_north_o, io_north_oe, io_east_oe, io_west_oe}), 64'd0);
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("rstg_after_active", 64'(active_o), 64'd0);
        chk("rstg_after_busy",   64'(busy_o),   64'd0);

        // Random requests and occasional resets; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i);
            #2;
            cfg_valid_i = ($urandom_range(0, 99) < 30);
            cfg_sel_i   = (SW+1)'($urandom_range(0, 7));
            rst_ni      = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk_i);
        #2;
        rst_ni      = 1'b1;
        cfg_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
